// File: rtl/bus_ram.sv
// bus_ram: single-port synchronous RAM behind a valid/ready request/response bus.
// One-cycle registered reads, write acknowledgements and response back-pressure.
// Out-of-range addresses (>= DEPTH) report rsp_err.
// Optional macro BUS_RAM_CLEAR_EN: after reset, sweep zeros into every word before accepting requests.
module bus_ram #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_rwn,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_rwn,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  // Storage index width; DEPTH <= 2**ADDR_W guarantees IDX_W <= ADDR_W.
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

`ifdef BUS_RAM_CLEAR_EN
  localparam state_t RST_STATE = ST_INIT;
`else
  localparam state_t RST_STATE = ST_RUN;
`endif

  state_t            state;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              accept;
  logic              consume;
  logic              in_range;
  logic [IDX_W-1:0]  idx;

  logic              mem_we;
  logic [IDX_W-1:0]  mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

`ifdef BUS_RAM_CLEAR_EN
  logic [IDX_W-1:0]  clr_cnt;
`endif

  // Unsigned compare one bit wider so DEPTH == 2**ADDR_W never overflows.
  assign in_range  = ({1'b0, req_addr} < (ADDR_W + 1)'(DEPTH));
  assign idx       = req_addr[IDX_W-1:0];
  assign req_ready = !rst && (state == ST_RUN) && (!rsp_valid || rsp_ready);
  assign accept    = req_valid && req_ready;
  assign consume   = rsp_valid && rsp_ready;

  // Single write port: the clear sweep owns it during INIT, bus writes otherwise.
  always_comb begin
    mem_we    = accept && !req_rwn && in_range;
    mem_waddr = idx;
    mem_wdata = req_wdata;
`ifdef BUS_RAM_CLEAR_EN
    if (!rst && state == ST_INIT) begin
      mem_we    = 1'b1;
      mem_waddr = clr_cnt;
      mem_wdata = '0;
    end
`endif
  end

  // Memory array write; contents are not reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // State, clear counter and response register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RST_STATE;
      rsp_valid <= 1'b0;
      rsp_rwn   <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
`ifdef BUS_RAM_CLEAR_EN
      clr_cnt   <= '0;
`endif
    end else begin
`ifdef BUS_RAM_CLEAR_EN
      if (state == ST_INIT) begin
        clr_cnt <= clr_cnt + IDX_W'(1);
        if (clr_cnt == IDX_W'(DEPTH - 1)) begin
          state <= ST_RUN;
        end
      end
`endif
      if (accept) begin
        rsp_valid <= 1'b1;
        rsp_rwn   <= req_rwn;
        rsp_err   <= !in_range;
        rsp_rdata <= (req_rwn && in_range) ? mem[idx] : '0;
      end else if (consume) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bus_ram.sv
// Scoreboard bench for bus_ram (ADDR_W=8, DATA_W=8, DEPTH=200).
// Build with BUS_RAM_CLEAR_EN to exercise the reset-time clear sweep.
module tb_bus_ram;

  localparam int unsigned AW    = 8;
  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 200;
  localparam int          BOUND = 500;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          req_rwn;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic          rsp_rwn;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;

  bus_ram #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_rwn   (req_rwn),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rwn   (rsp_rwn),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          rwn;
    logic [DW-1:0] rdata;
    logic          err;
  } rsp_t;

  rsp_t          exp_q[$];
  logic [DW-1:0] model [256];
  int            n_checks = 0;
  int            n_fail   = 0;
  int            rdy_mode = 0;   // 0: rsp_ready=1, 1: random, 2: rsp_ready=0
  int            stalls   = 0;

`ifdef BUS_RAM_CLEAR_EN
  localparam int SWEEP = DEPTH;
`else
  localparam int SWEEP = 0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_rdy();
    case (rdy_mode)
      0:       rsp_ready = 1'b1;
      1:       rsp_ready = 1'($urandom_range(0, 1));
      default: rsp_ready = 1'b0;
    endcase
  endtask

  // Reference behaviour of one accepted request: update storage, queue the response.
  task automatic model_accept(input logic rwn, input logic [AW-1:0] a, input logic [DW-1:0] d);
    rsp_t e;
    logic oor;
    oor = (int'(a) >= int'(DEPTH));
    e.rwn   = rwn;
    e.err   = oor;
    e.rdata = '0;
    if (!rwn) begin
      if (!oor) model[a] = d;
    end else if (!oor) begin
      e.rdata = model[a];
    end
    exp_q.push_back(e);
  endtask

  // Present one request from a negedge until accepted; returns at the next negedge.
  task automatic issue(input logic rwn, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n;
    n = 0;
    req_valid = 1'b1;
    req_rwn   = rwn;
    req_addr  = a;
    req_wdata = d;
    forever begin
      set_rdy();
      #1;
      if (req_ready === 1'b1) break;
      stalls++;
      n++;
      if (n > BOUND) begin
        check("req_accept_timeout", 32'(req_ready), 32'd1);
        break;
      end
      @(negedge clk);
    end
    if (n <= BOUND) model_accept(rwn, a, d);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic idle(input int cyc);
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    repeat (cyc) @(negedge clk);
  endtask

  // Count cycles with req_ready low after reset release; returns at a negedge.
  task automatic wait_ready(input string name, input int exp_cycles);
    int n;
    n = 0;
    forever begin
      #1;
      if (req_ready === 1'b1) break;
      n++;
      if (n > DEPTH + 10) break;
      @(negedge clk);
    end
    check(name, 32'(n), 32'(exp_cycles));
    @(negedge clk);
  endtask

  // Reset for cyc cycles; pending responses are discarded.
  task automatic do_reset(input int cyc);
    rst       = 1'b1;
    req_valid = 1'b0;
    repeat (cyc) @(negedge clk);
    exp_q.delete();
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    rst = 1'b0;
`ifdef BUS_RAM_CLEAR_EN
    for (int i = 0; i < int'(DEPTH); i++) model[i] = '0;
`endif
  endtask

  // Monitor: compare each consumed response against the scoreboard head.
  always @(negedge clk) begin
    rsp_t e;
    #2;
    if (rst === 1'b0 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", 32'(rsp_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("rsp", 32'({rsp_rwn, rsp_rdata, rsp_err}), 32'(e));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_rwn   = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    rsp_ready = 1'b1;
    @(negedge clk);
    do_reset(3);
    wait_ready("init_ready_cycles", SWEEP);

`ifdef BUS_RAM_CLEAR_EN
    // Cleared word reads zero; reset partway through the sweep restarts it.
    issue(1'b1, 8'h05, 8'h00);
    idle(2);
    repeat (8) @(negedge clk);
    do_reset(1);
    repeat (8) @(negedge clk);
    do_reset(1);
    wait_ready("sweep_restart_cycles", SWEEP);
`endif

    // Basic write then back-to-back read.
    rdy_mode = 0;
    issue(1'b0, 8'h10, 8'hA5);
    issue(1'b1, 8'h10, 8'h00);

    // Streaming: every address written then read at full rate.
    stalls = 0;
    for (int a = 0; a < 256; a++) issue(1'b0, AW'(a), DW'(a) ^ 8'hFF);
    for (int a = 0; a < 256; a++) issue(1'b1, AW'(a), 8'h00);
    check("stream_stalls", 32'(stalls), 32'd0);

    // Back-pressure: held read response, then release with a new read pending.
    issue(1'b0, 8'h20, 8'h3C);
    issue(1'b1, 8'h20, 8'h00);
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_rwn   = 1'b1;
    req_addr  = 8'h10;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_hold", 32'({rsp_valid, req_ready, rsp_rwn, rsp_rdata, rsp_err}),
            32'({1'b1, 1'b0, 1'b1, 8'h3C, 1'b0}));
      @(negedge clk);
    end
    stalls = 0;
    issue(1'b1, 8'h10, 8'h00);
    check("bp_release_stalls", 32'(stalls), 32'd0);

    // Out of range at the first illegal address, plus the last legal one.
    issue(1'b0, 8'hC8, 8'h77);
    issue(1'b1, 8'hC8, 8'h00);
    issue(1'b1, 8'hC7, 8'h00);
    issue(1'b0, 8'hFF, 8'h12);
    issue(1'b1, 8'hFF, 8'h00);

    // Randomised traffic with random response back-pressure.
    rdy_mode = 1;
    for (int i = 0; i < 300; i++) begin
      issue(1'($urandom_range(0, 1)), AW'($urandom_range(0, 255)), DW'($urandom));
    end
    rdy_mode = 0;
    idle(4);

    // Reset while a response is held.
    issue(1'b0, 8'h33, 8'h5E);
    issue(1'b1, 8'h33, 8'h00);
    rsp_ready = 1'b0;
    #1;
    check("pre_rst_rsp_valid", 32'(rsp_valid), 32'd1);
    do_reset(1);
    wait_ready("midop_ready_cycles", SWEEP);
    issue(1'b1, 8'h33, 8'h00);
    issue(1'b1, 8'h10, 8'h00);
    issue(1'b1, 8'hC7, 8'h00);

    idle(5);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_ram.md
# bus_ram

Parametrised single-port synchronous RAM behind a valid/ready request/response bus. It is the successor to the 8-bit combinational bus RAM. It adds:
- configurable address and data width and depth;
- registered one-cycle reads;
- write acknowledgements;
- response back-pressure;
- out-of-range error reporting;
- optional reset-time memory clearing.

It sits between a bus master (testbench driver or CPU-side adapter) and on-chip storage.

## Interface
- ADDR_W, 8, address width in bits.
- DATA_W, 8, data word width in bits.
- DEPTH, 2**ADDR_W, number of words implemented. Legal range is 1..2**ADDR_W.
- clk  input  1  clock; all logic is rising-edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request this cycle.
- req_rwn  input  1  1 = read, 0 = write (same sense as RWn).
- req_addr  input  ADDR_W  word address.
- req_wdata  input  DATA_W  write data; ignored on reads.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  master accepts the response.
- rsp_rwn  output  1  echo of the accepted request's req_rwn.
- rsp_rdata  output  DATA_W  read data. It is 0 for writes and for errors.
- rsp_err  output  1  the accepted address was >= DEPTH.

## Operation
- **Handshake.** A request is accepted on a rising edge where req_valid && req_ready. A response is consumed on a rising edge where rsp_valid && rsp_ready.
- **req_ready.** req_ready = (state == RUN) && (!rsp_valid || rsp_ready). It is combinational, so the block sustains one access per cycle with no bubble.
- **Write.** On acceptance, mem[req_addr] <= req_wdata if req_addr < DEPTH. The next cycle presents a response with rsp_rwn=0, rsp_rdata=0 and rsp_err=(req_addr >= DEPTH).
- **Read.** On acceptance, the response register loads mem[req_addr], or 0 with rsp_err=1 if the address is out of range. rsp_rwn=1.
- **Out-of-range write.** Dropped. Memory is unchanged.
- **Response stability.** The response register holds all rsp_* fields stable while rsp_valid && !rsp_ready. The master must hold req_* stable while req_valid && !req_ready.
- **rsp_valid update.** If a response is consumed and no request is accepted on the same edge, rsp_valid falls. A simultaneous consume and accept reloads the register and rsp_valid stays 1.
- **Back-to-back write then read.** A write to address A accepted at edge N, followed by a read of A accepted at edge N+1, returns the new data.
- **State machine.**
  - INIT: memory clear; present only with BUS_RAM_CLEAR_EN.
  - RUN: normal operation.
  - Reset enters INIT if compiled in, otherwise RUN.
  - INIT → RUN after the last word is cleared.

## Timing
- Reset values: req_ready=0 during reset; rsp_valid=0, rsp_rwn=0, rsp_rdata=0, rsp_err=0. The internal clear counter resets to 0.
- Latency: the response is valid on the cycle after acceptance (1 cycle). Throughput is 1 access per cycle with rsp_ready held high.
- Reset mid-operation: any pending response is discarded (rsp_valid=0 on the next cycle). Memory contents are retained unless BUS_RAM_CLEAR_EN is set, in which case the clear sweep restarts from address 0.
- Width: addresses compare as unsigned ADDR_W. With DEPTH = 2**ADDR_W, rsp_err is never asserted.

## Configuration
- BUS_RAM_CLEAR_EN defined:
  - After rst deasserts, the INIT state writes 0 to addresses 0..DEPTH-1, one word per cycle, using a clog2(DEPTH)-bit counter.
  - req_ready stays 0 for exactly DEPTH cycles after the rst deassertion edge, then the block enters RUN.
  - Reads of unwritten words return 0.
- Not defined:
  - There is no INIT state; req_ready may assert on the first cycle after reset.
  - Memory contents after power-up are undefined (X in simulation).

## Test plan
- **Write/read basic** (ADDR_W=8, DATA_W=8): write 0xA5 to 0x10, then read 0x10 → read response has rsp_rdata=0xA5, rsp_err=0, rsp_rwn=1. The write response has rsp_rwn=0 and rsp_rdata=0.
- **Streaming**: 256 consecutive writes (data = address XOR 0xFF) followed by 256 reads, with rsp_ready held at 1 → one response per cycle, no req_ready drop, all data matches.
- **Back-pressure**: hold rsp_ready=0 after a read of 0x20 → req_ready=0 and rsp_* stable for 5 cycles. Raise rsp_ready with a new read pending → it is accepted on the same edge the old response is consumed.
- **Out of range** (DEPTH=200): write 0x77 to 0xC8, then read 0xC8 → both responses have rsp_err=1 and rsp_rdata=0. mem[0x00..0xC7] is unchanged.
- **Reset mid-operation**: assert rst for 1 cycle while rsp_valid=1 and rsp_ready=0 → rsp_valid=0 on the next edge, and a read of a previously written address still returns its value (macro off).
- **BUS_RAM_CLEAR_EN** (DEPTH=16): req_ready=0 for exactly 16 cycles after reset, then read address 5 → 0x00. Asserting reset at cycle 8 of the sweep restarts it and gives another full 16 cycles.
